// File: rtl/aes_pkg.sv
// Shared types, constants and GF(2^8) helpers for the AES-256 inverse cipher.
package aes_pkg;

  localparam int NR        = 14;
  localparam int NK_ROUNDS = 15;

  typedef logic [127:0] state_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_FINAL = 2'd2,
    ST_DONE  = 2'd3
  } dec_state_e;

  // Inverse S-box, entry 0 in the most significant byte.
  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX[b];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul9(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ b;
  endfunction

  function automatic logic [7:0] gmul11(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
  endfunction

  function automatic logic [7:0] gmul13(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
  endfunction

  function automatic logic [7:0] gmul14(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey,
// then InvMixColumns unless i_final is set. Byte k = 4*column + row, byte 0 at bit 127.
module aes_inv_round
  import aes_pkg::*;
(
  input  state_t i_state,
  input  state_t i_rkey,
  input  logic   i_final,
  output state_t o_next_state
);

  logic [7:0] w_ark [16];
  logic [7:0] w_mix [16];

  // Row r rotates right by r columns, then bytes substitute and take the round key.
  always_comb begin
    w_ark = '{default: 8'h00};
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        w_ark[4*c + r] = inv_sbox(i_state[127 - 8*(4*((c + 4 - r) % 4) + r) -: 8])
                         ^ i_rkey[127 - 8*(4*c + r) -: 8];
      end
    end
  end

  // InvMixColumns on each of the four columns.
  always_comb begin
    w_mix = '{default: 8'h00};
    for (int c = 0; c < 4; c++) begin
      w_mix[4*c + 0] = gmul14(w_ark[4*c]) ^ gmul11(w_ark[4*c+1]) ^ gmul13(w_ark[4*c+2]) ^ gmul9(w_ark[4*c+3]);
      w_mix[4*c + 1] = gmul9(w_ark[4*c])  ^ gmul14(w_ark[4*c+1]) ^ gmul11(w_ark[4*c+2]) ^ gmul13(w_ark[4*c+3]);
      w_mix[4*c + 2] = gmul13(w_ark[4*c]) ^ gmul9(w_ark[4*c+1])  ^ gmul14(w_ark[4*c+2]) ^ gmul11(w_ark[4*c+3]);
      w_mix[4*c + 3] = gmul11(w_ark[4*c]) ^ gmul13(w_ark[4*c+1]) ^ gmul9(w_ark[4*c+2])  ^ gmul14(w_ark[4*c+3]);
    end
  end

  // The last round skips InvMixColumns.
  always_comb begin
    o_next_state = '0;
    for (int k = 0; k < 16; k++) begin
      o_next_state[127 - 8*k -: 8] = i_final ? w_ark[k] : w_mix[k];
    end
  end

endmodule

// File: rtl/aes_dec_core.sv
// Iterative AES-256 decrypt core: buffers 15 forward-order round keys and runs
// them backwards, one round per clock. Optional macro AES_DEC_KEY_ZEROIZE_EN adds
// key_flush_i, which wipes keys, state and result.
//
// Handshakes: a round key is accepted on any edge where rk_valid_i & en_i & ~busy_o
// (there is no back-pressure; keys offered while busy are dropped). A start is
// accepted on an edge where start_i & keys_ready_o & en_i in IDLE or DONE; starts
// at any other time are dropped, nothing is queued. done_o marks plaintext_o valid.
module aes_dec_core
  import aes_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_n,
  input  logic         en_i,
  input  logic         rk_valid_i,
  input  logic [127:0] rk_i,
  output logic         keys_ready_o,
  input  logic         start_i,
  input  logic [127:0] ciphertext_i,
  output logic         busy_o,
  output logic         done_o,
  output logic [127:0] plaintext_o,
`ifdef AES_DEC_KEY_ZEROIZE_EN
  input  logic         key_flush_i,
`endif
  output dec_state_e   dbg_state_o
);

  state_t     r_buf [NK_ROUNDS];
  logic [3:0] r_wp;
  logic       r_keys_ready;
  state_t     r_state;
  logic [3:0] r_rc;
  state_t     r_plaintext;
  dec_state_e r_fsm;
  dec_state_e w_fsm_next;

  logic   w_flush;
  logic   w_busy;
  logic   w_start;
  logic   w_key_we;
  state_t w_rkey;
  state_t w_round;

`ifdef AES_DEC_KEY_ZEROIZE_EN
  assign w_flush = key_flush_i & en_i;
`else
  assign w_flush = 1'b0;
`endif

  assign w_busy   = (r_fsm == ST_ROUND) || (r_fsm == ST_FINAL);
  assign w_start  = start_i & r_keys_ready & en_i & ((r_fsm == ST_IDLE) || (r_fsm == ST_DONE));
  assign w_key_we = rk_valid_i & en_i & ~w_busy & ~w_flush;
  assign w_rkey   = (r_fsm == ST_FINAL) ? r_buf[0] : r_buf[r_rc];

  aes_inv_round u_round (
    .i_state      (r_state),
    .i_rkey       (w_rkey),
    .i_final      (r_fsm == ST_FINAL),
    .o_next_state (w_round)
  );

  // Key buffer: forward-order writes, ready once rk[14] lands, cleared when a new set begins.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NK_ROUNDS; i++) r_buf[i] <= '0;
      r_wp         <= '0;
      r_keys_ready <= 1'b0;
    end else if (w_flush) begin
      for (int i = 0; i < NK_ROUNDS; i++) r_buf[i] <= '0;
      r_wp         <= '0;
      r_keys_ready <= 1'b0;
    end else if (w_key_we) begin
      r_buf[r_wp] <= rk_i;
      if (r_wp == 4'(NK_ROUNDS - 1)) begin
        r_wp         <= '0;
        r_keys_ready <= 1'b1;
      end else begin
        r_wp <= r_wp + 4'd1;
        if ((r_wp == 4'd0) && r_keys_ready) r_keys_ready <= 1'b0;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) r_fsm <= ST_IDLE;
    else        r_fsm <= w_fsm_next;
  end

  // FSM next state; en_i low holds the current state.
  always_comb begin
    w_fsm_next = r_fsm;
    if (en_i) begin
      case (r_fsm)
        ST_IDLE:  if (w_start) w_fsm_next = ST_ROUND;
        ST_ROUND: if (r_rc == 4'd1) w_fsm_next = ST_FINAL;
        ST_FINAL: w_fsm_next = ST_DONE;
        ST_DONE:  w_fsm_next = w_start ? ST_ROUND : ST_IDLE;
        default:  w_fsm_next = ST_IDLE;
      endcase
    end
    if (w_flush) w_fsm_next = ST_IDLE;
  end

  // Datapath: initial AddRoundKey on start, a round per ROUND cycle, result in FINAL.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= '0;
      r_rc        <= '0;
      r_plaintext <= '0;
    end else if (w_flush) begin
      r_state     <= '0;
      r_plaintext <= '0;
    end else if (en_i) begin
      case (r_fsm)
        ST_IDLE, ST_DONE: begin
          if (w_start) begin
            r_state <= ciphertext_i ^ r_buf[NK_ROUNDS - 1];
            r_rc    <= 4'(NR - 1);
          end
        end
        ST_ROUND: begin
          r_state <= w_round;
          if (r_rc != 4'd1) r_rc <= r_rc - 4'd1;
        end
        ST_FINAL: r_plaintext <= w_round;
        default: ;
      endcase
    end
  end

  assign keys_ready_o = r_keys_ready;
  assign busy_o       = w_busy;
  assign done_o       = (r_fsm == ST_DONE);
  assign plaintext_o  = r_plaintext;
  assign dbg_state_o  = r_fsm;

endmodule

// File: tb/tb_aes_dec_core.sv
// Bench for aes_dec_core: FIPS-197 C.3 vector, random blocks from a forward-cipher
// model, key-load handshake, back-to-back, hold, async reset and (with
// AES_DEC_KEY_ZEROIZE_EN) key flush.
module tb_aes_dec_core;
  import aes_pkg::*;

  localparam logic [255:0] KEY_C3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] CT_C3  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] PT_C3  = 128'h00112233445566778899aabbccddeeff;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en_i;
  logic         rk_valid_i;
  logic [127:0] rk_i;
  logic         keys_ready_o;
  logic         start_i;
  logic [127:0] ciphertext_i;
  logic         busy_o;
  logic         done_o;
  logic [127:0] plaintext_o;
  dec_state_e   dbg_state;
`ifdef AES_DEC_KEY_ZEROIZE_EN
  logic         key_flush_i;
`endif

  logic [127:0] exp_q [$];
  int           n_vec = 0;
  int           n_err = 0;
  logic [7:0]   sbox_t [256];
  logic [127:0] rk_tab [15];

  aes_dec_core dut (
    .clk_i        (clk),
    .rst_n        (rst_n),
    .en_i         (en_i),
    .rk_valid_i   (rk_valid_i),
    .rk_i         (rk_i),
    .keys_ready_o (keys_ready_o),
    .start_i      (start_i),
    .ciphertext_i (ciphertext_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .plaintext_o  (plaintext_o),
`ifdef AES_DEC_KEY_ZEROIZE_EN
    .key_flush_i  (key_flush_i),
`endif
    .dbg_state_o  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, got no summary, expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- reference forward cipher ----------------
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  task automatic init_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_t[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                  ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {sbox_t[x[31:24]], sbox_t[x[23:16]], sbox_t[x[15:8]], sbox_t[x[7:0]]};
  endfunction

  task automatic expand_key(input logic [255:0] key);
    logic [31:0] w [60];
    logic [31:0] tmp;
    logic [7:0]  rcon;
    rcon = 8'h01;
    for (int i = 0; i < 8; i++) w[i] = key[255 - 32*i -: 32];
    for (int i = 8; i < 60; i++) begin
      tmp = w[i-1];
      if (i % 8 == 0) begin
        tmp  = sub_word({tmp[23:0], tmp[31:24]}) ^ {rcon, 24'h0};
        rcon = gm(rcon, 8'h02);
      end else if (i % 8 == 4) begin
        tmp = sub_word(tmp);
      end
      w[i] = w[i-8] ^ tmp;
    end
    for (int r = 0; r < 15; r++) rk_tab[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] aes_enc(input logic [127:0] pt);
    logic [127:0] s;
    logic [127:0] t;
    logic [7:0]   a [4];
    s = pt ^ rk_tab[0];
    for (int r = 1; r <= 14; r++) begin
      t = '0;
      for (int c = 0; c < 4; c++)
        for (int w = 0; w < 4; w++)
          t[127 - 8*(4*c + w) -: 8] = sbox_t[s[127 - 8*(4*((c + w) % 4) + w) -: 8]];
      if (r < 14) begin
        s = t;
        for (int c = 0; c < 4; c++) begin
          for (int w = 0; w < 4; w++) a[w] = s[127 - 8*(4*c + w) -: 8];
          t[127 - 8*(4*c)     -: 8] = gm(a[0], 8'h02) ^ gm(a[1], 8'h03) ^ a[2] ^ a[3];
          t[127 - 8*(4*c + 1) -: 8] = a[0] ^ gm(a[1], 8'h02) ^ gm(a[2], 8'h03) ^ a[3];
          t[127 - 8*(4*c + 2) -: 8] = a[0] ^ a[1] ^ gm(a[2], 8'h02) ^ gm(a[3], 8'h03);
          t[127 - 8*(4*c + 3) -: 8] = gm(a[0], 8'h03) ^ a[1] ^ a[2] ^ gm(a[3], 8'h02);
        end
      end
      s = t ^ rk_tab[r];
    end
    return s;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic load_keys();
    for (int r = 0; r < 15; r++) begin
      rk_valid_i = 1'b1;
      rk_i       = rk_tab[r];
      @(posedge clk); #1;
    end
    rk_valid_i = 1'b0;
  endtask

  // Drives one start edge (E0); returns 1 time unit after it.
  task automatic issue_start(input logic [127:0] ct, input logic [127:0] pt);
    exp_q.push_back(pt);
    ciphertext_i = ct;
    start_i      = 1'b1;
    @(posedge clk); #1;
    start_i      = 1'b0;
    ciphertext_i = rand128();
  endtask

  // Counts edges from E0 (n = 1) until done_o is seen, bounded.
  task automatic wait_done(output int n);
    n = 1;
    while (done_o !== 1'b1 && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    n_vec++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
    n_vec++; if (done_o !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b expected 0", done_o); end
    n_vec++; if (keys_ready_o !== 1'b0) begin n_err++; $display("FAIL reset_keys_ready: got %b expected 0", keys_ready_o); end
    n_vec++; if (plaintext_o !== 128'h0) begin n_err++; $display("FAIL reset_plaintext: got %h expected 0", plaintext_o); end
    n_vec++; if (dbg_state !== ST_IDLE) begin n_err++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, ST_IDLE); end
  endtask

  task automatic test_no_keys();
    ciphertext_i = CT_C3;
    start_i      = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    for (int k = 0; k < 20; k++) begin
      n_vec++;
      if (busy_o !== 1'b0 || done_o !== 1'b0) begin
        n_err++; $display("FAIL no_keys_idle: got busy=%b done=%b expected 0 0", busy_o, done_o);
      end
      @(posedge clk); #1;
    end
    expand_key(KEY_C3);
    for (int r = 0; r < 15; r++) begin
      rk_valid_i = 1'b1;
      rk_i       = rk_tab[r];
      @(posedge clk); #1;
      n_vec++;
      if (keys_ready_o !== (r == 14)) begin
        n_err++; $display("FAIL key_load_ready: after write %0d got %b expected %b", r, keys_ready_o, (r == 14));
      end
    end
    rk_valid_i = 1'b0;
  endtask

  task automatic test_c3();
    int n;
    logic [127:0] e;
    issue_start(CT_C3, PT_C3);
    wait_done(n);
    e = exp_q.pop_front();
    n_vec++; if (n !== 15) begin n_err++; $display("FAIL c3_latency: got %0d edges expected 15", n); end
    n_vec++; if (plaintext_o !== e) begin n_err++; $display("FAIL c3_plaintext: got %h expected %h", plaintext_o, e); end
    @(posedge clk); #1;
    n_vec++; if (done_o !== 1'b0) begin n_err++; $display("FAIL c3_done_pulse: got %b expected 0", done_o); end
    n_vec++; if (plaintext_o !== PT_C3) begin n_err++; $display("FAIL c3_plaintext_hold: got %h expected %h", plaintext_o, PT_C3); end
  endtask

  task automatic test_back_to_back();
    logic [127:0] pts [4];
    logic [127:0] cts [4];
    logic [127:0] e;
    int n;
    pts[0] = PT_C3; cts[0] = CT_C3;
    pts[1] = PT_C3; cts[1] = CT_C3;
    for (int i = 2; i < 4; i++) begin
      pts[i] = rand128();
      cts[i] = aes_enc(pts[i]);
    end
    issue_start(cts[0], pts[0]);
    for (int i = 0; i < 4; i++) begin
      wait_done(n);
      e = exp_q.pop_front();
      n_vec++; if (n !== 15) begin n_err++; $display("FAIL b2b_latency[%0d]: got %0d edges expected 15", i, n); end
      n_vec++; if (plaintext_o !== e) begin n_err++; $display("FAIL b2b_plaintext[%0d]: got %h expected %h", i, plaintext_o, e); end
      if (i < 3) issue_start(cts[i+1], pts[i+1]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_hold();
    int n;
    logic [127:0] e;
    issue_start(CT_C3, PT_C3);
    rk_valid_i = 1'b1;
    n = 1;
    while (n < 5) begin
      rk_i = rand128();
      @(posedge clk); #1; n++;
    end
    en_i = 1'b0;
    repeat (5) begin
      rk_i = rand128();
      @(posedge clk); #1; n++;
    end
    en_i = 1'b1;
    while (done_o !== 1'b1 && n < 60) begin
      rk_i = rand128();
      @(posedge clk); #1; n++;
    end
    rk_valid_i = 1'b0;
    e = exp_q.pop_front();
    n_vec++; if (n !== 20) begin n_err++; $display("FAIL hold_latency: got %0d edges expected 20", n); end
    n_vec++; if (plaintext_o !== e) begin n_err++; $display("FAIL hold_plaintext: got %h expected %h", plaintext_o, e); end
    en_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      n_vec++; if (done_o !== 1'b1) begin n_err++; $display("FAIL hold_done_kept[%0d]: got %b expected 1", k, done_o); end
    end
    en_i = 1'b1;
    @(posedge clk); #1;
    n_vec++; if (done_o !== 1'b0) begin n_err++; $display("FAIL hold_done_release: got %b expected 0", done_o); end
    // keys untouched by the dropped writes
    issue_start(CT_C3, PT_C3);
    wait_done(n);
    e = exp_q.pop_front();
    n_vec++; if (n !== 15) begin n_err++; $display("FAIL hold_keys_latency: got %0d edges expected 15", n); end
    n_vec++; if (plaintext_o !== e) begin n_err++; $display("FAIL hold_keys_plaintext: got %h expected %h", plaintext_o, e); end
    @(posedge clk); #1;
    // write pointer untouched: a fresh set must clear ready on its first write
    for (int r = 0; r < 15; r++) begin
      rk_valid_i = 1'b1;
      rk_i       = rk_tab[r];
      @(posedge clk); #1;
      n_vec++;
      if (keys_ready_o !== (r == 14)) begin
        n_err++; $display("FAIL hold_wp_ready: after write %0d got %b expected %b", r, keys_ready_o, (r == 14));
      end
    end
    rk_valid_i = 1'b0;
  endtask

  task automatic test_random_key();
    int n;
    logic [127:0] pt;
    logic [127:0] e;
    expand_key({rand128(), rand128()});
    load_keys();
    for (int i = 0; i < 3; i++) begin
      pt = rand128();
      issue_start(aes_enc(pt), pt);
      n = 1;
      while (done_o !== 1'b1 && n < 60) begin
        start_i      = (i == 0) && (n == 7);
        ciphertext_i = rand128();
        @(posedge clk); #1; n++;
      end
      start_i = 1'b0;
      e = exp_q.pop_front();
      n_vec++; if (n !== 15) begin n_err++; $display("FAIL rkey_latency[%0d]: got %0d edges expected 15", i, n); end
      n_vec++; if (plaintext_o !== e) begin n_err++; $display("FAIL rkey_plaintext[%0d]: got %h expected %h", i, plaintext_o, e); end
      @(posedge clk); #1;
    end
    expand_key(KEY_C3);
    load_keys();
  endtask

  task automatic test_async_reset();
    int n;
    logic [127:0] e;
    issue_start(CT_C3, PT_C3);
    repeat (7) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL areset_busy: got %b expected 0", busy_o); end
    n_vec++; if (done_o !== 1'b0) begin n_err++; $display("FAIL areset_done: got %b expected 0", done_o); end
    n_vec++; if (plaintext_o !== 128'h0) begin n_err++; $display("FAIL areset_plaintext: got %h expected 0", plaintext_o); end
    n_vec++; if (keys_ready_o !== 1'b0) begin n_err++; $display("FAIL areset_keys_ready: got %b expected 0", keys_ready_o); end
    n_vec++; if (dbg_state !== ST_IDLE) begin n_err++; $display("FAIL areset_state: got %0d expected %0d", dbg_state, ST_IDLE); end
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    ciphertext_i = CT_C3;
    start_i      = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    for (int k = 0; k < 18; k++) begin
      n_vec++;
      if (busy_o !== 1'b0 || done_o !== 1'b0) begin
        n_err++; $display("FAIL areset_start_ignored: got busy=%b done=%b expected 0 0", busy_o, done_o);
      end
      @(posedge clk); #1;
    end
    load_keys();
    issue_start(CT_C3, PT_C3);
    wait_done(n);
    e = exp_q.pop_front();
    n_vec++; if (n !== 15) begin n_err++; $display("FAIL areset_reload_latency: got %0d edges expected 15", n); end
    n_vec++; if (plaintext_o !== e) begin n_err++; $display("FAIL areset_reload_plaintext: got %h expected %h", plaintext_o, e); end
    @(posedge clk); #1;
  endtask

`ifdef AES_DEC_KEY_ZEROIZE_EN
  task automatic test_zeroize();
    int n;
    logic [127:0] e;
    issue_start(CT_C3, PT_C3);
    wait_done(n);
    e = exp_q.pop_front();
    n_vec++; if (plaintext_o !== e) begin n_err++; $display("FAIL flush_pre_plaintext: got %h expected %h", plaintext_o, e); end
    key_flush_i  = 1'b1;
    start_i      = 1'b1;
    ciphertext_i = CT_C3;
    @(posedge clk); #1;
    key_flush_i = 1'b0;
    start_i     = 1'b0;
    n_vec++; if (keys_ready_o !== 1'b0) begin n_err++; $display("FAIL flush_keys_ready: got %b expected 0", keys_ready_o); end
    n_vec++; if (plaintext_o !== 128'h0) begin n_err++; $display("FAIL flush_plaintext: got %h expected 0", plaintext_o); end
    n_vec++; if (dbg_state !== ST_IDLE) begin n_err++; $display("FAIL flush_state: got %0d expected %0d", dbg_state, ST_IDLE); end
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    n_vec++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL flush_start_ignored: got %b expected 0", busy_o); end
    load_keys();
    issue_start(CT_C3, PT_C3);
    wait_done(n);
    e = exp_q.pop_front();
    n_vec++; if (n !== 15) begin n_err++; $display("FAIL flush_reload_latency: got %0d edges expected 15", n); end
    n_vec++; if (plaintext_o !== e) begin n_err++; $display("FAIL flush_reload_plaintext: got %h expected %h", plaintext_o, e); end
    @(posedge clk); #1;
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    rst_n        = 1'b0;
    en_i         = 1'b1;
    rk_valid_i   = 1'b0;
    rk_i         = '0;
    start_i      = 1'b0;
    ciphertext_i = '0;
`ifdef AES_DEC_KEY_ZEROIZE_EN
    key_flush_i  = 1'b0;
`endif
    init_sbox();
    test_reset();
    test_no_keys();
    test_c3();
    test_back_to_back();
    test_hold();
    test_random_key();
    test_async_reset();
`ifdef AES_DEC_KEY_ZEROIZE_EN
    test_zeroize();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/aes_dec_core.md
# aes_dec_core

Iterative AES-256 inverse cipher that decrypts one 128-bit block in 14 round cycles. It is the decrypt-direction counterpart of the CTR-mode encrypt top, used for ECB/CBC-style block decryption. It buffers the 15 forward-order round keys streamed from the key scheduler, then consumes them in reverse order. The block sits beside the key scheduler and shares its round-key stream and `en_i` hold convention.

## Interface
Parameters: none. AES-256 only: `NR = 14`, 15 round keys.

- `clk_i`  in  1  clock
- `rst_n`  in  1  reset; one clock; reset is asynchronous and active-low
- `en_i`  in  1  hold; when 0, every register (state, keys, FSM, counters) holds and inputs are ignored
- `rk_valid_i`  in  1  round-key write strobe
- `rk_i`  in  128  round key; forward order rk[0]..rk[14]
- `keys_ready_o`  out  1  all 15 keys of the current set are loaded
- `start_i`  in  1  request decryption of `ciphertext_i`
- `ciphertext_i`  in  128  input block; sampled only on the start edge
- `busy_o`  out  1  decryption in progress
- `done_o`  out  1  one-cycle pulse; `plaintext_o` is valid
- `plaintext_o`  out  128  result; held until the next final round
- `key_flush_i`  in  1  present only with `AES_DEC_KEY_ZEROIZE_EN`

## Operation
**Key buffer**
- 15×128 registers with a 4-bit write pointer `wp`.
- `rk_valid_i & en_i & ~busy_o` writes `rk_i` to `buf[wp]`, then `wp++`.
- When `wp == 14` is written, `wp` returns to 0 and `keys_ready_o` rises.
- A write with `wp == 0` while `keys_ready_o` is high clears `keys_ready_o` (start of a new set).
- `rk_valid_i` during `busy_o` is dropped; `wp` is unchanged.

**FSM states:** IDLE, ROUND, FINAL, DONE
- **IDLE / DONE:** `start_i & keys_ready_o & en_i` loads `state <= ciphertext_i ^ buf[14]` and `rc <= 13`, then goes to ROUND. `start_i` without `keys_ready_o` is ignored. DONE with no start goes to IDLE.
- **ROUND:** `state <= InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ buf[rc])`, `rc--`. When `rc == 1`, go to FINAL.
- **FINAL:** `plaintext_o <= InvSubBytes(InvShiftRows(state)) ^ buf[0]`, go to DONE.
- `busy_o` = ROUND | FINAL. `done_o` = (state == DONE).

**Other rules**
- `start_i` in ROUND or FINAL is ignored. There is no queueing.
- Byte order: bit 127 is byte 0, column-major as in FIPS-197.
- `rc` is 4 bits wide and never wraps below 1 in ROUND.

## Timing
- Start sampled at edge E0. ROUND occupies cycles E0..E13 (13 cycles), FINAL occupies E13..E14, and `done_o` is high for exactly one cycle after E14. Latency is 15 edges.
- Back-to-back operation: a start in DONE gives a throughput of one block per 15 cycles.
- While `en_i = 0`, latency extends by exactly the number of held cycles and `done_o` stays high if held in DONE.
- Reset values: FSM = IDLE, `busy_o = 0`, `done_o = 0`, `keys_ready_o = 0`, `plaintext_o = 0`, `state = 0`, `wp = 0`, `rc = 0`, all buffer entries 0.
- Reset mid-operation aborts immediately. Keys must be reloaded.

## Configuration
`AES_DEC_KEY_ZEROIZE_EN`
- **Defined:** adds `key_flush_i`.
- `key_flush_i & en_i` zeroes all 15 buffer entries, `state` and `plaintext_o`, and sets `wp = 0`, `keys_ready_o = 0`, FSM = IDLE on the next edge.
- Flush has priority over start and over key writes.
- **Undefined:** the port is absent, and key material persists until overwritten or reset.

## Structure
- `aes_pkg` holds:
  - `NR = 14`
  - `NK_ROUNDS = 15`
  - `state_t` (`logic [127:0]`)
  - the inverse S-box function `inv_sbox(byte)`
  - GF(2^8) helpers `xtime`, `gmul9`, `gmul11`, `gmul13`, `gmul14`
  - the FSM enum `dec_state_e`
- One combinational sub-module, `aes_inv_round`, with inputs `state`, `rkey`, `final` and output `next_state`. It applies InvShiftRows, InvSubBytes, AddRoundKey, and InvMixColumns when `final == 0`.
- The top holds the key buffer, FSM, counter and output register.

## Test plan
- **FIPS-197 C.3:** load the expanded round keys of key `000102…1f`, then start with `8ea2b7ca516745bfeafc49904b496089`. Expect `done_o` 15 edges later with `00112233445566778899aabbccddeeff`.
- **No keys:** `start_i` with `keys_ready_o = 0` gives `busy_o` staying 0 and no `done_o`. After the 15th key write, `keys_ready_o = 1` on the next cycle.
- **Back-to-back:** start in DONE with the same ciphertext gives a second `done_o` exactly 15 cycles after the first, with the same plaintext.
- **Hold:** drop `en_i` for 5 cycles mid-ROUND gives `done_o` at 20 edges and a correct plaintext. `rk_valid_i` during `busy_o` leaves `wp` and the keys unchanged.
- **Async reset at round 7:** outputs drop to 0 immediately. After reset, start is ignored until keys are reloaded.
- **With `AES_DEC_KEY_ZEROIZE_EN`:** flush after `done_o` gives `keys_ready_o = 0` and `plaintext_o = 0`. Reloading the keys gives C.3 correct again.
